synchronous_fifo: RTL and testbench
===================================

Name: synchronous_fifo

Overview:
Single-clock, parameterised first-in first-out buffer with registered read data and full/empty status flags. It decouples a producer and a consumer running on the same clock and is the storage element behind the block-level verification interface (intf). Writes are gated by full and reads are gated by empty, so misuse never corrupts state.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits
DEPTH, 8, number of entries; must be a power of two and at least 2 (elaboration-time assertion)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
w_en  input  1  write request; data_in is captured when w_en=1 and full=0
r_en  input  1  read request; head word is popped when r_en=1 and empty=0
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  registered read data
full  output  1  high when DEPTH entries are stored
empty  output  1  high when 0 entries are stored

Behaviour:
- Reset: rst_n=0 immediately clears write and read pointers, data_out=0, empty=1, full=0. Reset asserted mid-operation discards all contents. Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits wide. The low bits index memory; the MSB is a wrap bit. Pointers wrap naturally modulo 2*DEPTH.
- Flags are combinational from the pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
- Write: on a rising edge with w_en=1 and full=0, mem[wr_ptr low bits] <= data_in and wr_ptr increments. A write while full is silently dropped; no pointer or memory change.
- Read: on a rising edge with r_en=1 and empty=0, data_out <= mem[rd_ptr low bits] and rd_ptr increments. Latency is one clock from the sampled r_en to valid data_out. A read while empty is ignored and data_out holds its last value. data_out also holds whenever no read occurs.
- Simultaneous w_en and r_en:
  - Neither full nor empty: both occur and the occupancy is unchanged.
  - When full: only the read occurs, and full deasserts after the edge.
  - When empty: only the write occurs, and empty deasserts after the edge. There is no fall-through; the word is readable from the next cycle.
- full and empty are never simultaneously high.
- No X is propagated on data_out after reset.

Decomposition:
- A shared package fifo_pkg holds:
  - default DATA_WIDTH/DEPTH localparams
  - the pointer-width function (clog2(DEPTH)+1)
- One natural sub-module, fifo_mem: a DATA_WIDTH x DEPTH register array with a synchronous write port and a synchronous registered read port. The top level holds the pointers, flag logic and gating.
- The verification interface intf bundles these signals, clocked by clk:
  - rst_n, wr_en, rd_en, data_in, data_out, full, empty
  - wr_en maps to w_en and rd_en maps to r_en.

Test Plan:
- Reset: hold rst_n=0 for one cycle with random w_en/r_en -> empty=1, full=0, data_out=0; release -> flags unchanged until the first write.
- Write-full: write 9 words 0x01..0x09 back-to-back with r_en=0 -> full=1 right after the 8th write edge, the 9th write is dropped, and empty=0 throughout.
- Drain in order: from the full state, read 8 times -> data_out sequence 0x01..0x08 (one cycle after each read); empty=1 after the 8th read; a 9th read leaves data_out=0x08.
- Empty read: after reset, assert r_en for 3 cycles -> data_out stays 0, empty stays 1, and the pointers are unchanged.
- Simultaneous access: with 4 entries stored, assert w_en and r_en together for 10 cycles with an incrementing data_in -> occupancy stays 4, no flag toggles, and output order is preserved. With the FIFO full, assert both -> the read returns the head word, the write is dropped, and full=0 afterwards.
- Wrap-around and async reset:
  - Perform 20 interleaved write/read cycles so both pointers wrap -> data integrity holds and the flags are correct at each boundary.
  - Pulse rst_n low between clock edges mid-stream -> empty=1 and data_out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 8;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/intf.sv
// Block-level verification bundle for the synchronous FIFO, clocked by clk.
interface intf #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH
) (
  input logic clk
);
  logic                  rst_n;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
endinterface

// File: rtl/fifo_mem.sv
// DATA_WIDTH x DEPTH register array: synchronous write, registered read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  localparam int unsigned ADDR_W    = ptr_width(DEPTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value whenever no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO: wrap-bit pointers, flag decode and request gating.
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam int unsigned ADDR_W = PTR_W - 1;

  // Reject depths the wrap-bit scheme cannot represent.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("synchronous_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_write_c;
  logic             do_read_c;

  // Flags decode straight from the pointers so reset clears them at once.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  // Misuse gating: writes blocked when full, reads blocked when empty.
  assign do_write_c = w_en && !full;
  assign do_read_c  = r_en && !empty;

  // Pointer advance; wraps modulo 2*DEPTH through natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_read_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_write_c),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (do_read_c),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed self-checking bench for synchronous_fifo (DATA_WIDTH=8, DEPTH=8).
module tb_synchronous_fifo;

  logic clk;
  int   n_cmp;
  int   n_bad;

  intf #(.DATA_WIDTH(8)) bus (.clk(clk));

  synchronous_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (8)
  ) dut (
    .clk      (clk),
    .rst_n    (bus.rst_n),
    .w_en     (bus.wr_en),
    .r_en     (bus.rd_en),
    .data_in  (bus.data_in),
    .data_out (bus.data_out),
    .full     (bus.full),
    .empty    (bus.empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_dout;
  int         pre;

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset with random requests on the inputs.
    bus.rst_n = 1'b0;
    drive(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
    step();
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_dout", 32'(bus.data_out), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    bus.rst_n = 1'b1;
    step();
    check("rel_empty", 32'(bus.empty), 32'd1);
    check("rel_full", 32'(bus.full), 32'd0);

    // Reads while empty are ignored.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      step();
      check("erd_dout", 32'(bus.data_out), 32'd0);
      check("erd_empty", 32'(bus.empty), 32'd1);
    end

    // Fill with 0x01..0x09; ninth write is dropped.
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      step();
      check("wf_empty", 32'(bus.empty), 32'd0);
      check("wf_full", 32'(bus.full), (i >= 8) ? 32'd1 : 32'd0);
    end

    // Drain in order, then one extra read while empty.
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      step();
      check("dr_dout", 32'(bus.data_out), (i <= 8) ? 32'(i) : 32'h08);
      check("dr_empty", 32'(bus.empty), (i >= 8) ? 32'd1 : 32'd0);
      check("dr_full", 32'(bus.full), 32'd0);
    end

    // Four entries 0x10..0x13, then 10 simultaneous read/write cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i));
      step();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 8'(8'h14 + k));
      step();
      check("sim_dout", 32'(bus.data_out), 32'(8'h10 + k));
      check("sim_empty", 32'(bus.empty), 32'd0);
      check("sim_full", 32'(bus.full), 32'd0);
    end
    // Contents now 0x1A..0x1D; top up to full with 0x1E..0x21.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'h1E + i));
      step();
    end
    check("top_full", 32'(bus.full), 32'd1);
    // Both requests while full: read head, write of 0xEE dropped.
    drive(1'b1, 1'b1, 8'hEE);
    step();
    check("fboth_dout", 32'(bus.data_out), 32'h1A);
    check("fboth_full", 32'(bus.full), 32'd0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      step();
      check("fdr_dout", 32'(bus.data_out), 32'(8'h1B + i));
    end
    check("fdr_empty", 32'(bus.empty), 32'd1);

    // Interleaved traffic across pointer wrap against a queue model.
    q.delete();
    exp_dout = 8'h21;
    for (int k = 0; k < 20; k++) begin
      logic w;
      logic r;
      w = (k % 4) != 3;
      r = (k % 3) != 0;
      drive(w, r, 8'(8'h40 + k));
      pre = q.size();
      if (r && pre > 0) exp_dout = q.pop_front();
      if (w && pre < 8) q.push_back(8'(8'h40 + k));
      step();
      check("wrap_dout", 32'(bus.data_out), 32'(exp_dout));
      check("wrap_empty", 32'(bus.empty), (q.size() == 0) ? 32'd1 : 32'd0);
      check("wrap_full", 32'(bus.full), (q.size() == 8) ? 32'd1 : 32'd0);
    end

    // Mid-stream asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'(8'hA0 + i));
      step();
    end
    drive(1'b0, 1'b1, 8'h00);
    step();
    check("pre_ar_dout_nz", 32'(bus.data_out != 8'h00), 32'd1);
    drive(1'b0, 1'b0, 8'h00);
    #2;
    bus.rst_n = 1'b0;
    #1;
    check("ar_empty", 32'(bus.empty), 32'd1);
    check("ar_dout", 32'(bus.data_out), 32'd0);
    check("ar_full", 32'(bus.full), 32'd0);
    #1;
    bus.rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    step();
    check("post_ar_dout", 32'(bus.data_out), 32'd0);
    check("post_ar_empty", 32'(bus.empty), 32'd1);
    drive(1'b0, 1'b0, 8'h00);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
